// File: rtl/bus_decoder_pkg.sv
// Shared definitions for the bus_decoder block: FSM state encoding,
// default address-window constants and the window decode helper.
package bus_decoder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_DONE   = 2'd2
  } state_e;

  localparam logic [15:0] DEF_SRAM_TOP  = 16'h7FFF;
  localparam logic [15:0] DEF_IO_BASE   = 16'hA000;
  localparam logic [15:0] DEF_IO_TOP    = 16'hAFFF;
  localparam logic [15:0] DEF_ROM_BASE  = 16'hC000;
  localparam logic [15:0] DEF_PAGE_ADDR = 16'hBFFF;

  typedef struct packed {
    logic sram;
    logic io;
    logic rom;
  } sel_t;

  // Priority-ordered so that overlapping windows can never raise two selects.
  function automatic sel_t decode_addr(input logic [15:0] addr,
                                       input logic [15:0] sram_top,
                                       input logic [15:0] io_base,
                                       input logic [15:0] io_top,
                                       input logic [15:0] rom_base);
    sel_t s;
    s = '0;
    if (addr <= sram_top)                        s.sram = 1'b1;
    else if ((addr >= io_base) && (addr <= io_top)) s.io = 1'b1;
    else if (addr >= rom_base)                   s.rom  = 1'b1;
    return s;
  endfunction

endpackage

// File: rtl/bus_decoder_sync2.sv
// Two-flop synchronizer for signals arriving asynchronously to the clock.
module sync2 #(
  parameter int WIDTH = 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] stage1_q;
  logic [WIDTH-1:0] stage2_q;

  // Two back-to-back flops; stage2 is the metastability-settled value.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stage1_q <= '0;
      stage2_q <= '0;
    end else begin
      stage1_q <= d_i;
      stage2_q <= stage1_q;
    end
  end

  assign q_o = stage2_q;

endmodule

// File: rtl/bus_decoder.sv
// bus_decoder: address decoder and bus-cycle tracker for an asynchronous
// E-strobe CPU bus. Selects are registered; during a bus cycle they are
// frozen and a one-clock o_cycle_done marks the end of every cycle.
// Optional feature: define PAGE_REG_EN to add a 4-bit SRAM page register
// written at PAGE_ADDR; without it o_page is constant zero.
module bus_decoder
  import bus_decoder_pkg::*;
#(
  parameter logic [15:0] SRAM_TOP  = DEF_SRAM_TOP,
  parameter logic [15:0] IO_BASE   = DEF_IO_BASE,
  parameter logic [15:0] IO_TOP    = DEF_IO_TOP,
  parameter logic [15:0] ROM_BASE  = DEF_ROM_BASE,
  parameter logic [15:0] PAGE_ADDR = DEF_PAGE_ADDR
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_E,
  input  logic        i_RW,
  input  logic [15:0] i_addr,
  input  logic [7:0]  i_data,
  output logic        o_sram_ce,
  output logic        o_rom_ce,
  output logic        o_io_ce,
  output logic [3:0]  o_page,
  output logic        o_cycle_done
);

  logic [1:0]  sync_q;
  logic        e_s;
  logic        rw_s;
  logic        e_d3_q;
  logic        e_rise;
  logic        e_fall;
  state_e      state_q;
  sel_t        sel_d;
  sel_t        sel_q;
  logic        done_q;
  logic [15:0] addr_cap_q;
  logic        rw_cap_q;

  sync2 #(.WIDTH(2)) u_sync (
    .clk_i (i_clk),
    .rst_i (i_reset),
    .d_i   ({i_E, i_RW}),
    .q_o   (sync_q)
  );

  assign e_s  = sync_q[1];
  assign rw_s = sync_q[0];

  // Third copy of E for edge detection.
  always_ff @(posedge i_clk) begin
    if (i_reset) e_d3_q <= 1'b0;
    else         e_d3_q <= e_s;
  end

  assign e_rise = e_s & ~e_d3_q;
  assign e_fall = ~e_s & e_d3_q;

  // Combinational window decode of the live address; the page register
  // address is carved out so it never raises a select.
  always_comb begin
    sel_d = decode_addr(i_addr, SRAM_TOP, IO_BASE, IO_TOP, ROM_BASE);
`ifdef PAGE_REG_EN
    if (i_addr == PAGE_ADDR) sel_d = '0;
`endif
  end

  // Bus-cycle FSM: track the address in IDLE, freeze in ACTIVE, pulse in DONE.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q <= ST_IDLE;
      sel_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          sel_q      <= sel_d;
          addr_cap_q <= i_addr;
          rw_cap_q   <= rw_s;
          done_q     <= 1'b0;
          // A glitch seen as rise and fall together is not a bus cycle.
          if (e_rise && !e_fall) state_q <= ST_ACTIVE;
        end
        ST_ACTIVE: begin
          if (e_fall) begin
            state_q <= ST_DONE;
            done_q  <= 1'b1;
          end
        end
        ST_DONE: begin
          done_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign o_sram_ce    = sel_q.sram;
  assign o_io_ce      = sel_q.io;
  assign o_rom_ce     = sel_q.rom;
  assign o_cycle_done = done_q;

`ifdef PAGE_REG_EN
  logic [3:0] page_q;
  logic       unused_data_hi;

  // Page register loads on the completion of a write to PAGE_ADDR.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      page_q <= 4'h0;
    end else if ((state_q == ST_DONE) && (addr_cap_q == PAGE_ADDR) && !rw_cap_q) begin
      page_q <= i_data[3:0];
    end
  end

  assign o_page         = page_q;
  assign unused_data_hi = ^i_data[7:4];
`else
  logic unused_page_inputs;

  assign o_page             = 4'h0;
  assign unused_page_inputs = ^{i_data, PAGE_ADDR, addr_cap_q, rw_cap_q};
`endif

endmodule

// File: tb/tb_bus_decoder.sv
// Self-checking bench for bus_decoder: directed scenarios with literal
// expectations plus randomized bus traffic against a behavioural model.
module tb_bus_decoder;

  localparam logic [15:0] SRAM_TOP  = 16'h7FFF;
  localparam logic [15:0] IO_BASE   = 16'hA000;
  localparam logic [15:0] IO_TOP    = 16'hAFFF;
  localparam logic [15:0] ROM_BASE  = 16'hC000;
  localparam logic [15:0] PAGE_ADDR = 16'hBFFF;

  logic        clk = 1'b0;
  logic        rst;
  logic        e;
  logic        rw;
  logic [15:0] addr;
  logic [7:0]  data;
  logic        o_sram_ce, o_rom_ce, o_io_ce, o_cycle_done;
  logic [3:0]  o_page;

  int n_checks = 0;
  int n_fail   = 0;

  bus_decoder #(
    .SRAM_TOP(SRAM_TOP), .IO_BASE(IO_BASE), .IO_TOP(IO_TOP),
    .ROM_BASE(ROM_BASE), .PAGE_ADDR(PAGE_ADDR)
  ) dut (
    .i_clk        (clk),
    .i_reset      (rst),
    .i_E          (e),
    .i_RW         (rw),
    .i_addr       (addr),
    .i_data       (data),
    .o_sram_ce    (o_sram_ce),
    .o_rom_ce     (o_rom_ce),
    .o_io_ce      (o_io_ce),
    .o_page       (o_page),
    .o_cycle_done (o_cycle_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // E and RW become visible to the decoder two clocks after sampling; a
  // bus cycle begins when the visible E goes high and ends when it goes low.
  bit          m_valid = 0;
  logic [2:0]  m_eseen;     // [0] newest sample, [1] visible level, [2] previous visible level
  logic [1:0]  m_rwseen;
  int          m_phase;     // 0 between cycles, 1 inside a cycle, 2 completion clock
  logic [2:0]  m_sel;       // {sram, io, rom}
  logic [3:0]  m_page;
  logic [15:0] m_cap_addr;
  logic        m_cap_rw;

  function automatic logic [2:0] win(input logic [15:0] a);
`ifdef PAGE_REG_EN
    if (a == PAGE_ADDR) return 3'b000;
`endif
    if (a <= SRAM_TOP) return 3'b100;
    if (a >= IO_BASE && a <= IO_TOP) return 3'b010;
    if (a >= ROM_BASE) return 3'b001;
    return 3'b000;
  endfunction

  always @(posedge clk) begin
    logic vis_up, vis_down;
    if (rst) begin
      m_valid  = 1;
      m_eseen  = '0;
      m_rwseen = '0;
      m_phase  = 0;
      m_sel    = '0;
      m_page   = '0;
    end else begin
      vis_up   = m_eseen[1] && !m_eseen[2];
      vis_down = !m_eseen[1] && m_eseen[2];
      if (m_phase == 0) begin
        m_sel = win(addr);
        if (vis_up && !vis_down) begin
          m_phase    = 1;
          m_cap_addr = addr;
          m_cap_rw   = m_rwseen[1];
        end
      end else if (m_phase == 1) begin
        if (vis_down) m_phase = 2;
      end else begin
`ifdef PAGE_REG_EN
        if (m_cap_addr == PAGE_ADDR && !m_cap_rw) m_page = data[3:0];
`endif
        m_phase = 0;
      end
      m_eseen  = {m_eseen[1], m_eseen[0], e};
      m_rwseen = {m_rwseen[0], rw};
    end
  end

  // Cycle-by-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (m_valid) begin
      chk("selects", {13'd0, o_sram_ce, o_io_ce, o_rom_ce}, {13'd0, m_sel});
      chk("cycle_done", {15'd0, o_cycle_done}, {15'd0, (m_phase == 2)});
      chk("page", {12'd0, o_page}, {12'd0, m_page});
      chk("one_select_max", {15'd0, ($countones({o_sram_ce, o_io_ce, o_rom_ce}) <= 1)}, 16'd1);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic wait_done(output int cyc);
    cyc = -1;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      if (o_cycle_done) begin
        cyc = i;
        return;
      end
    end
  endtask

  task automatic bus_cycle(input logic [15:0] a, input logic r, input logic [7:0] d,
                           input int elen, output int dcyc);
    addr = a; rw = r; data = d;
    repeat (3) @(negedge clk);
    e = 1'b1;
    repeat (elen) @(negedge clk);
    e = 1'b0;
    wait_done(dcyc);
    @(negedge clk);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int dc;
    int pulses;
    logic [3:0] exp_page;
    logic [15:0] edges [11] = '{16'h0000, 16'h7FFF, 16'h8000, 16'h9FFF, 16'hA000,
                                16'hAFFF, 16'hB000, 16'hBFFE, 16'hBFFF, 16'hC000, 16'hFFFF};

    rst = 1'b1; e = 1'b1; rw = 1'b1; addr = 16'h0000; data = 8'h00;
    repeat (3) @(negedge clk);
    chk("rst_sram", {15'd0, o_sram_ce}, 16'd0);
    chk("rst_io",   {15'd0, o_io_ce},   16'd0);
    chk("rst_rom",  {15'd0, o_rom_ce},  16'd0);
    chk("rst_done", {15'd0, o_cycle_done}, 16'd0);
    chk("rst_page", {12'd0, o_page}, 16'd0);
    e = 1'b0; rst = 1'b0;
    repeat (3) @(negedge clk);

    // SRAM read: select one clock after the address, done 3 clocks after E falls.
    addr = 16'h1234; rw = 1'b1;
    @(negedge clk);
    chk("sram_latency", {15'd0, o_sram_ce}, 16'd1);
    @(negedge clk);
    e = 1'b1;
    repeat (20) @(negedge clk);
    e = 1'b0;
    wait_done(dc);
    chk("done_after_fall", dc[15:0], 16'd3);
    pulses = 0;
    repeat (8) begin
      @(negedge clk);
      if (o_cycle_done) pulses++;
    end
    chk("single_done_pulse", pulses[15:0], 16'd0);

    // I/O then ROM.
    addr = 16'hA010;
    repeat (2) @(negedge clk);
    chk("io_select", {13'd0, o_sram_ce, o_io_ce, o_rom_ce}, 16'b010);
    bus_cycle(16'hA010, 1'b1, 8'h00, 6, dc);
    chk("io_done", dc[15:0], 16'd3);
    addr = 16'hC000;
    repeat (2) @(negedge clk);
    chk("rom_select", {13'd0, o_sram_ce, o_io_ce, o_rom_ce}, 16'b001);
    bus_cycle(16'hC000, 1'b1, 8'h00, 6, dc);

    // Page register write.
`ifdef PAGE_REG_EN
    exp_page = 4'hB;
`else
    exp_page = 4'h0;
`endif
    addr = 16'hBFFF; rw = 1'b0; data = 8'h0B;
    repeat (2) @(negedge clk);
    chk("page_addr_no_select", {13'd0, o_sram_ce, o_io_ce, o_rom_ce}, 16'd0);
    bus_cycle(16'hBFFF, 1'b0, 8'h0B, 5, dc);
    chk("page_value", {12'd0, o_page}, {12'd0, exp_page});

    // Address change while a cycle is in progress.
    rw = 1'b1;
    addr = 16'h0100;
    repeat (3) @(negedge clk);
    e = 1'b1;
    repeat (4) @(negedge clk);
    addr = 16'hC000;
    repeat (4) @(negedge clk);
    chk("held_sram_active", {13'd0, o_sram_ce, o_io_ce, o_rom_ce}, 16'b100);
    e = 1'b0;
    wait_done(dc);
    chk("held_done_lat", dc[15:0], 16'd3);
    chk("held_sram_done", {13'd0, o_sram_ce, o_io_ce, o_rom_ce}, 16'b100);
    repeat (2) @(negedge clk);
    chk("rom_after_done", {13'd0, o_sram_ce, o_io_ce, o_rom_ce}, 16'b001);

    // Reset in the middle of a page write aborts it.
    addr = 16'hBFFF; rw = 1'b0; data = 8'h05;
    repeat (3) @(negedge clk);
    e = 1'b1;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    e = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    pulses = 0;
    repeat (8) begin
      @(negedge clk);
      if (o_cycle_done) pulses++;
    end
    chk("abort_no_done", pulses[15:0], 16'd0);
    chk("abort_no_page", {12'd0, o_page}, 16'd0);
`ifdef PAGE_REG_EN
    exp_page = 4'h7;
`endif
    bus_cycle(16'hBFFF, 1'b0, 8'h07, 4, dc);
    chk("after_abort_done", dc[15:0], 16'd3);
    chk("after_abort_page", {12'd0, o_page}, {12'd0, exp_page});

    // Randomized traffic, checked every clock by the model.
    for (int it = 0; it < 300; it++) begin
      int elen, rstpos;
      if ($urandom_range(0, 1) == 0) addr = edges[$urandom_range(0, 10)];
      else                           addr = 16'($urandom);
      rw   = 1'($urandom);
      data = 8'($urandom);
      repeat ($urandom_range(2, 4)) @(negedge clk);
      elen   = $urandom_range(1, 10);
      rstpos = ($urandom_range(0, 24) == 0) ? $urandom_range(0, elen - 1) : -1;
      e = 1'b1;
      for (int j = 0; j < elen; j++) begin
        if (j == rstpos) rst = 1'b1;
        if ($urandom_range(0, 7) == 0) addr = 16'($urandom);
        @(negedge clk);
        rst = 1'b0;
      end
      e = 1'b0;
      repeat ($urandom_range(0, 6)) @(negedge clk);
    end
    repeat (10) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
